conv_window_feeder: RTL
=======================

# conv_window_feeder

Streaming sliding-window generator that sits upstream of the convolution reduction tree. Accepts one signed pixel per handshake in raster order and emits a complete KERNEL×KERNEL window as a flat vector of KERNEL*KERNEL operands, ready to feed the tree's `inputs` array directly. Holds KERNEL-1 line buffers plus a KERNEL×KERNEL register window, and emits windows only at fully interior positions (no padding). Valid/ready backpressure is on both sides.

## Interface
- DATA_WIDTH, 16, pixel and window element width (signed).
- KERNEL, 3, window side length, ≥2; KERNEL*KERNEL matches the tree's N_INPUTS.
- IMG_WIDTH, 8, pixels per image row, ≥KERNEL.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  feeder accepts pixel this cycle.
- in_data  in  DATA_WIDTH signed  pixel value.
- in_last  in  1  pixel is the final pixel of the frame.
- out_valid  out  1  window present.
- out_ready  in  1  consumer accepts window.
- window  out  [0:KERNEL*KERNEL-1] × DATA_WIDTH signed  window operands.
- out_last  out  1  window was produced by the in_last pixel.

## Operation
- Accept: the pixel is taken when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). It is low while rst_n is low.
- Counters: col runs 0..IMG_WIDTH-1 and wraps to 0, incrementing row on wrap. row saturates at KERNEL-1. Both counters advance only on accept.
- Line buffers LB[0..KERNEL-2] are each IMG_WIDTH deep and addressed by col.
  - On accept: LB[j][col] <= LB[j-1][col] for j≥1, and LB[0][col] <= in_data.
  - Reads use pre-write contents.
- New column, top to bottom: LB[KERNEL-2][col], …, LB[0][col], in_data.
- The window register shifts left by one column on accept, and the new column enters at c=KERNEL-1.
- Window ordering: index r*KERNEL+c. r=0 is the oldest (top) row and c=0 is the leftmost (oldest) column. Elements are passed through unmodified, with no arithmetic and no width change.
- Window emitted iff the accepted pixel has row==KERNEL-1 and col≥KERNEL-1 (pre-increment values). This yields (H-KERNEL+1)×(IMG_WIDTH-KERNEL+1) windows per frame.
- Stale columns from the previous row enter the window at col<KERNEL-1. This is harmless because emission is gated.
- out_last = in_last of the pixel that produced the window.
- in_last behaviour:
  - After accepting a pixel with in_last, col and row reset to 0.
  - This applies even if in_last arrives mid-row, which is treated as a frame abort with no further windows.
  - Line buffer contents are left as is.
- Accepting a pixel that produces no window leaves out_valid/window unchanged.

## Timing
- Latency: one cycle from the accepting edge to out_valid=1 with the corresponding window.
- out_valid/window/out_last are held stable while out_valid && !out_ready.
- Simultaneous out_ready and an accept in the same cycle:
  - The old window retires and the new window, if any, is loaded on the same edge.
  - Otherwise out_valid drops to 0.
- Throughput: one pixel per cycle with out_ready held high.
- Reset (async, any time including mid-frame):
  - out_valid=0, out_last=0, window all 0, col=0, row=0.
  - Line buffer RAM is not reset.
  - The first pixel after reset is row 0, col 0 of a new frame.

## Structure
- Shared package conv_pkg:
  - pixel_t (signed DATA_WIDTH) typedef.
  - Defaults for KERNEL/IMG_WIDTH.
  - Window index helper constant KSQ=KERNEL*KERNEL.
  - The tree op encoding (00 add, 01 sub, 10 max, 11 min) stays there too.
- One sub-module: conv_line_buffer, a single IMG_WIDTH-deep read-before-write row store with shared address and write enable. It is instantiated KERNEL-1 times in a chain.
- Top: counters, window shift register, output register, handshake.

## Test plan
- Basic 3×3, IMG_WIDTH=4, 4×4 frame, pixels 0..15, out_ready=1:
  - Exactly 4 windows, 1 cycle after pixels 10, 11, 14, 15.
  - First window = {0,1,2,4,5,6,8,9,10}.
  - Last window = {5,6,7,9,10,11,13,14,15} with out_last=1.
- Backpressure: same frame, out_ready low for 3 cycles after the first window:
  - window holds {0,1,…,10} stable and in_ready=0.
  - No pixel lost; the remaining 3 windows match the basic case.
- Back-to-back frames: two 4×4 frames (second frame values 100..115) with no gap:
  - Second frame's first window = {100,101,102,104,105,106,108,109,110}.
  - Nothing emitted from pixels straddling the frames.
- Early in_last: in_last on pixel 9 (row 2, col 1):
  - No windows emitted.
  - Next pixels 0..15 produce the 4 basic-case windows.
- Async reset mid-frame: assert rst_n=0 after pixel 11 while out_valid=1:
  - out_valid=0 and window=0 immediately.
  - A fresh frame then reproduces the basic case.
- Tree integration, op=00: basic frame window sums equal 45, 54, 81, 90.

Source files
------------

// File: rtl/conv_pkg.sv
//------------------------------------------------------------------------------
// Module : conv_pkg
// Brief  : Shared types and defaults for the convolution feeder and reduction tree.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int KERNEL_DEFAULT     = 3;
    localparam int IMG_WIDTH_DEFAULT  = 8;
    localparam int KSQ                = KERNEL_DEFAULT * KERNEL_DEFAULT;

    typedef logic signed [DATA_WIDTH_DEFAULT-1:0] pixel_t;

    typedef enum logic [1:0] {
        TREE_OP_ADD = 2'b00,
        TREE_OP_SUB = 2'b01,
        TREE_OP_MAX = 2'b10,
        TREE_OP_MIN = 2'b11
    } tree_op_e;

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
//------------------------------------------------------------------------------
// Module : conv_line_buffer
// Brief  : One image row of storage; read-before-write on a shared address.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = IMG_WIDTH_DEFAULT,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_addr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);

    logic signed [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Row storage is deliberately not reset; contents are only used once refilled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/conv_window_feeder.sv
//------------------------------------------------------------------------------
// Module : conv_window_feeder
// Brief  : Raster-order pixel stream to KERNEL x KERNEL interior windows.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int KERNEL     = KERNEL_DEFAULT,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] window [0:KERNEL*KERNEL-1],
    output logic                         out_last
);

    localparam int C_CW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int C_RW  = $clog2(KERNEL);
    localparam int C_KSQ = KERNEL * KERNEL;

    localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(IMG_WIDTH - 1);
    localparam logic [C_CW-1:0] C_COL_EMIT = C_CW'(KERNEL - 1);
    localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(KERNEL - 1);

    logic [C_CW-1:0]              r_col;
    logic [C_RW-1:0]              r_row;
    logic                         w_accept;
    logic                         w_emit;
    logic signed [DATA_WIDTH-1:0] w_lb_rdata [0:KERNEL-2];
    logic signed [DATA_WIDTH-1:0] w_newcol   [0:KERNEL-1];
    logic signed [DATA_WIDTH-1:0] w_next_win [0:C_KSQ-1];
    logic signed [DATA_WIDTH-1:0] r_win      [0:C_KSQ-1];
    logic signed [DATA_WIDTH-1:0] r_window   [0:C_KSQ-1];
    logic                         r_out_valid;
    logic                         r_out_last;

    assign in_ready = rst_n && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_emit   = w_accept && (r_row == C_ROW_LAST) && (r_col >= C_COL_EMIT);

    // Line buffers form a vertical shift chain: LB[0] holds the previous row.
    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
        logic signed [DATA_WIDTH-1:0] w_wdata;
        if (j == 0) begin : g_head
            assign w_wdata = in_data;
        end else begin : g_link
            assign w_wdata = w_lb_rdata[j-1];
        end
        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .AW         (C_CW)
        ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (r_col),
            .i_wdata (w_wdata),
            .o_rdata (w_lb_rdata[j])
        );
    end

    for (genvar r = 0; r < KERNEL; r++) begin : g_newcol
        if (r < KERNEL - 1) begin : g_buf
            assign w_newcol[r] = w_lb_rdata[KERNEL-2-r];
        end else begin : g_pix
            assign w_newcol[r] = in_data;
        end
    end

    // Window after this accept: every row shifts left, new column enters on the right.
    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        for (genvar c = 0; c < KERNEL; c++) begin : g_col
            if (c < KERNEL - 1) begin : g_shift
                assign w_next_win[r*KERNEL+c] = r_win[r*KERNEL+c+1];
            end else begin : g_enter
                assign w_next_win[r*KERNEL+c] = w_newcol[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_win <= '{default: '0};
        end else if (w_accept) begin
            r_win <= w_next_win;
            if (in_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (r_col == C_COL_LAST) begin
                r_col <= '0;
                if (r_row != C_ROW_LAST) begin
                    r_row <= r_row + C_RW'(1);
                end
            end else begin
                r_col <= r_col + C_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_window    <= '{default: '0};
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
            r_window    <= w_next_win;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign window    = r_window;

endmodule

`default_nettype wire
